// File: rtl/matrix_operand_reader_if.sv
// BRAM read port and row-major element stream of the matrix operand reader.
// master = reader side, slave = BRAM/consumer side.
interface matrix_operand_reader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14
);
    logic                  bram_rd_en;
    logic [ADDR_WIDTH-1:0] bram_rd_addr;
    logic [DATA_WIDTH-1:0] bram_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [7:0]            out_row;
    logic [7:0]            out_col;
    logic                  out_last;

    modport master (
        output bram_rd_en, bram_rd_addr,
        input  bram_rd_data,
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  bram_rd_en, bram_rd_addr,
        output bram_rd_data,
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_operand_reader.sv
// Fetches a stored matrix by slot ID, validates its shape from metadata word 0
// and streams the elements row-major through a 2-entry output FIFO.
module matrix_operand_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned BLOCK_SIZE = 1152,
    parameter int unsigned META_WORDS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [2:0]              i_matrix_id,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [3:0]              o_status,
    output logic [7:0]              o_shape_rows,
    output logic [7:0]              o_shape_cols,
    matrix_operand_reader_if.master io_bus
);
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned CAPACITY = BLOCK_SIZE - META_WORDS;

    typedef enum logic [2:0] {
        S_IDLE, S_META_REQ, S_META_WAIT, S_CHECK, S_STREAM, S_FIN
    } state_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_BUSY      = 4'd1,
        ST_SUCCESS   = 4'd2,
        ST_ERR_DIM   = 4'd3,
        ST_ERR_ID    = 4'd4,
        ST_ERR_EMPTY = 4'd5
    } status_e;

    state_e                r_state,  w_state_nxt;
    status_e               r_status, w_status_nxt;
    status_e               r_result, w_result_nxt;
    logic                  r_busy,   w_busy_nxt;
    logic                  r_done,   w_done_nxt;
    logic [7:0]            r_rows,   w_rows_nxt;
    logic [7:0]            r_cols,   w_cols_nxt;
    logic [CNT_W-1:0]      r_count,  w_count_nxt;
    logic [ADDR_WIDTH-1:0] r_base,   w_base_nxt;
    logic                  w_stream_init;

    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_fifo_cnt;
    logic                  r_pend;
    logic [CNT_W-1:0]      r_issue_k;
    logic [CNT_W-1:0]      r_out_k;
    logic [7:0]            r_out_row;
    logic [7:0]            r_out_col;

    logic                  w_out_valid;
    logic                  w_out_last;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_meta_rd;
    logic                  w_data_rd;
    logic [ADDR_WIDTH-1:0] w_data_addr;
    logic [CNT_W-1:0]      w_elems;

    assign w_out_valid = (r_fifo_cnt != 2'd0);
    assign w_out_last  = (r_out_k == r_count - CNT_W'(1));
    assign w_pop       = w_out_valid && io_bus.out_ready;
    assign w_elems     = CNT_W'(r_rows) * CNT_W'(r_cols);

    // Occupancy after this cycle's push/pop; a new read lands two edges later, so cap at 2.
    assign w_occ       = 3'(r_fifo_cnt) + 3'(r_pend) - 3'(w_pop);
    assign w_meta_rd   = (r_state == S_META_REQ);
    assign w_data_rd   = (r_state == S_STREAM) && (r_issue_k < r_count) && (w_occ < 3'd2);
    assign w_data_addr = r_base + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(r_issue_k);

    assign io_bus.bram_rd_en   = !rst && (w_meta_rd || w_data_rd);
    assign io_bus.bram_rd_addr = w_data_rd ? w_data_addr : (w_meta_rd ? r_base : '0);
    assign io_bus.out_valid    = w_out_valid;
    assign io_bus.out_data     = r_fifo[r_rd_ptr];
    assign io_bus.out_row      = r_out_row;
    assign io_bus.out_col      = r_out_col;
    assign io_bus.out_last     = w_out_valid && w_out_last;

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_status     = r_status;
    assign o_shape_rows = r_rows;
    assign o_shape_cols = r_cols;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_status <= ST_IDLE;
            r_result <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rows   <= '0;
            r_cols   <= '0;
            r_count  <= '0;
            r_base   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            r_result <= w_result_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_rows   <= w_rows_nxt;
            r_cols   <= w_cols_nxt;
            r_count  <= w_count_nxt;
            r_base   <= w_base_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_status_nxt  = r_status;
        w_result_nxt  = r_result;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_rows_nxt    = r_rows;
        w_cols_nxt    = r_cols;
        w_count_nxt   = r_count;
        w_base_nxt    = r_base;
        w_stream_init = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_busy_nxt   = 1'b1;
                    w_status_nxt = ST_BUSY;
                    w_rows_nxt   = '0;
                    w_cols_nxt   = '0;
                    w_count_nxt  = '0;
                    w_base_nxt   = ADDR_WIDTH'(32'(i_matrix_id) * BLOCK_SIZE);
                    if (i_matrix_id == 3'd0) begin
                        w_result_nxt = ST_ERR_ID;
                        w_state_nxt  = S_FIN;
                    end else begin
                        w_state_nxt  = S_META_REQ;
                    end
                end
            end
            S_META_REQ: w_state_nxt = S_META_WAIT;
            S_META_WAIT: begin
                w_rows_nxt  = io_bus.bram_rd_data[31:24];
                w_cols_nxt  = io_bus.bram_rd_data[23:16];
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (r_rows == 8'd0 || r_cols == 8'd0) begin
                    w_result_nxt = ST_ERR_EMPTY;
                    w_state_nxt  = S_FIN;
                end else if (w_elems > CNT_W'(CAPACITY)) begin
                    w_result_nxt = ST_ERR_DIM;
                    w_state_nxt  = S_FIN;
                end else begin
                    w_count_nxt   = w_elems;
                    w_stream_init = 1'b1;
                    w_state_nxt   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_pop && w_out_last) begin
                    w_result_nxt = ST_SUCCESS;
                    w_state_nxt  = S_FIN;
                end
            end
            S_FIN: begin
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_status_nxt = r_result;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stream datapath: read issue, FIFO occupancy and output row/col indices.
    always_ff @(posedge clk) begin
        if (rst || w_stream_init) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= '0;
            r_pend     <= 1'b0;
            r_issue_k  <= '0;
            r_out_k    <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
        end else begin
            r_pend     <= w_data_rd;
            r_fifo_cnt <= r_fifo_cnt + 2'(r_pend) - 2'(w_pop);
            if (w_data_rd) begin
                r_issue_k <= r_issue_k + CNT_W'(1);
            end
            if (r_pend) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_out_k  <= r_out_k + CNT_W'(1);
                if (r_out_col == r_cols - 8'd1) begin
                    r_out_col <= '0;
                    r_out_row <= r_out_row + 8'd1;
                end else begin
                    r_out_col <= r_out_col + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_pend) begin
            r_fifo[r_wr_ptr] <= io_bus.bram_rd_data;
        end
    end
endmodule
